conv3x3_window_ctrl: RTL and testbench
======================================

# conv3x3_window_ctrl

Sequencer that drives the combinational `mac_3x3` datapath across a whole feature map. It performs a valid-padding (no border) 3x3 convolution over an `IMG_H` x `IMG_W` map held in a single-port pixel RAM with 1-cycle read latency. For each output position it fetches the nine window pixels, presents them to `mac_3x3`, registers `mac_out`, and emits the result on a valid/ready stream. Kernel weights are driven into `mac_3x3` elsewhere; this block only sequences pixels and results.

## Interface
- `DATA_WIDTH`, default `DATA_WIDTH` from cnn_params.vh (16): pixel/result width, signed Q format.
- `FRAC_BITS`, default `FRAC_BITS` from cnn_params.vh (8): fractional bits. Informational only; the block does no arithmetic on data.
- `IMG_W`, default 8: map width in pixels, must be ≥ 3.
- `IMG_H`, default 8: map height in pixels, must be ≥ 3.
- `ADDR_WIDTH`, default 6: pixel RAM address width, must satisfy 2^ADDR_WIDTH ≥ IMG_W*IMG_H.

Ports:
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — begin one full-map pass; sampled only in IDLE.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse after the final output handshake.
- `pix_rd_en`  out  1  — pixel RAM read strobe.
- `pix_addr`  out  ADDR_WIDTH  — read address, row-major: `y*IMG_W + x`.
- `pix_rd_data`  in  DATA_WIDTH  — RAM data, valid one cycle after `pix_rd_en`.
- `px0`..`px8`  out  DATA_WIDTH each  — registered window taps to `mac_3x3`; tap k = 3*r + c.
- `mac_out`  in  DATA_WIDTH  — combinational result from `mac_3x3`.
- `out_valid`  out  1  — result available.
- `out_ready`  in  1  — downstream accepts the result.
- `out_data`  out  DATA_WIDTH  — registered `mac_out`.
- `out_row`  out  8  — output row of `out_data`, range 0..IMG_H-3.
- `out_col`  out  8  — output column of `out_data`, range 0..IMG_W-3.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, COMPUTE, OUT, DONE.
- Output coordinate counters `row`/`col`. A 4-bit tap counter `k` runs 0..8, with r = k/3 and c = k%3.
- **IDLE**
  - `start` = 1: clear `row`, `col`, `k`, go to FETCH.
  - `start` in any other state is ignored.
- **FETCH**
  - `pix_rd_en` = 1 and `pix_addr` = (row+r)*IMG_W + (col+c) for the current k.
  - Data returned for tap k−1 is written into `px(k−1)`.
  - After k = 8 is issued, go to CAPTURE.
- **CAPTURE**
  - `pix_rd_en` = 0.
  - Write `pix_rd_data` into `px8`.
  - Go to COMPUTE.
- **COMPUTE**
  - Taps are now stable at `mac_3x3`.
  - Register `out_data` <= `mac_out`, `out_row` <= row, `out_col` <= col.
  - Set `out_valid` = 1 and go to OUT.
- **OUT**
  - Hold `out_valid`, `out_data`, `out_row` and `out_col` stable until `out_valid && out_ready`.
  - On handshake, `out_valid` drops.
  - If row = IMG_H−3 and col = IMG_W−3, go to DONE.
  - Otherwise advance: col+1, wrapping to 0 with row+1 at col = IMG_W−3. Reset k = 0 and go to FETCH.
- **DONE**
  - `done` = 1 for exactly one cycle, `busy` stays high, then go to IDLE.
- One pass emits (IMG_H−2)*(IMG_W−2) results in raster order.
- `px0`..`px8` are not cleared between windows; every tap is overwritten before COMPUTE.

## Timing
- Reset (asynchronous, active-high): state = IDLE. All of these go to 0:
  - `busy`, `done`, `pix_rd_en`, `pix_addr`
  - `px0`..`px8`
  - `out_valid`, `out_data`, `out_row`, `out_col`
- Reset asserted mid-pass aborts the pass immediately. No `done` is produced, and there is no partial state on release.
- Let E0 be the edge that samples `start`. `pix_rd_en` is high for the 9 cycles following E0..E8.
- Per window: 9 FETCH + 1 CAPTURE + 1 COMPUTE cycles. `out_valid` rises at E11.
- With `out_ready` held high, the next window's first read follows the handshake edge, giving a steady throughput of one result per 12 cycles.
- Each cycle of `out_ready` = 0 in OUT adds one cycle of latency. No reads are issued while stalled.
- `done` is high in the cycle after the last handshake. `busy` falls on the following edge.
- `start` held high through DONE→IDLE starts a new pass from IDLE on the next edge.

## Test plan
- **All-ones run.** IMG_W = IMG_H = 4, all pixels 256 (1.0), all weights 256, `out_ready` = 1, pulse `start`.
  - Exactly 4 results of 2304 (9.0) at (row,col) (0,0), (0,1), (1,0), (1,1).
  - `done` pulses once, 48 cycles after E0.
- **Address order.** Same configuration, first window.
  - `pix_addr` sequence is 0,1,2,4,5,6,8,9,10 on consecutive cycles.
  - Second window is 1,2,3,5,6,7,9,10,11.
  - `out_valid` first rises at E11.
- **Ramp image.** Pixel[a] = a*256, centre-tap weight `w4` = 256, other weights 0.
  - Results are 5*256, 6*256, 9*256, 10*256.
- **Backpressure.** Hold `out_ready` = 0 for 5 cycles on the second result.
  - `out_data`, `out_row` and `out_col` stay stable.
  - `pix_rd_en` stays 0 during the stall.
  - `done` is delayed by exactly 5 cycles.
- **Start while busy.** Pulse `start` during FETCH and during OUT.
  - No restart, the same 4 results, and a single `done`.
- **Reset mid-pass.** Assert `rst` during CAPTURE of window 2.
  - All outputs read 0 asynchronously and the FSM is in IDLE.
  - A subsequent `start` yields the full 4 correct results from (0,0).

Source files
------------

// File: rtl/conv3x3_window_ctrl.sv
// conv3x3_window_ctrl: walks a 3x3 valid-padding window over an IMG_H x IMG_W
// map held in a 1-cycle-latency pixel RAM, feeds the nine taps to mac_3x3,
// registers its result and emits it on a valid/ready stream.
//
// Stream handshake: out_valid rises together with a new out_data/out_row/
// out_col and all three hold stable until a rising edge that sees
// out_valid && out_ready; that edge is the transfer and out_valid drops on it.
module conv3x3_window_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pix_rd_en,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [DATA_WIDTH-1:0] pix_rd_data,
  output logic [DATA_WIDTH-1:0] px0,
  output logic [DATA_WIDTH-1:0] px1,
  output logic [DATA_WIDTH-1:0] px2,
  output logic [DATA_WIDTH-1:0] px3,
  output logic [DATA_WIDTH-1:0] px4,
  output logic [DATA_WIDTH-1:0] px5,
  output logic [DATA_WIDTH-1:0] px6,
  output logic [DATA_WIDTH-1:0] px7,
  output logic [DATA_WIDTH-1:0] px8,
  input  logic [DATA_WIDTH-1:0] mac_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            out_row,
  output logic [7:0]            out_col,
  output logic [2:0]            dbg_state
);

  // The Q-format fraction width only documents the data; the block never
  // does arithmetic on pixels. This empty block is taken only when the
  // binary point would fall outside the word.
  if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_outside_word
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMPUTE = 3'd3,
    S_OUT     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_row;
  logic [7:0]            r_col;
  logic [3:0]            r_k;
  logic [DATA_WIDTH-1:0] r_px [0:8];
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [7:0]            r_out_row;
  logic [7:0]            r_out_col;

  logic [1:0]            w_tap_r;
  logic [1:0]            w_tap_c;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_last_tap;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_hs;

  assign w_last_tap = (r_k == 4'd8);
  assign w_last_col = (r_col == 8'(IMG_W - 3));
  assign w_last_row = (r_row == 8'(IMG_H - 3));
  assign w_hs       = r_out_valid && out_ready;

  // Tap index k -> window row/column (k = 3*r + c).
  always_comb begin
    w_tap_r = 2'd0;
    w_tap_c = 2'd0;
    case (r_k)
      4'd1: begin w_tap_r = 2'd0; w_tap_c = 2'd1; end
      4'd2: begin w_tap_r = 2'd0; w_tap_c = 2'd2; end
      4'd3: begin w_tap_r = 2'd1; w_tap_c = 2'd0; end
      4'd4: begin w_tap_r = 2'd1; w_tap_c = 2'd1; end
      4'd5: begin w_tap_r = 2'd1; w_tap_c = 2'd2; end
      4'd6: begin w_tap_r = 2'd2; w_tap_c = 2'd0; end
      4'd7: begin w_tap_r = 2'd2; w_tap_c = 2'd1; end
      4'd8: begin w_tap_r = 2'd2; w_tap_c = 2'd2; end
      default: begin w_tap_r = 2'd0; w_tap_c = 2'd0; end
    endcase
  end

  assign w_addr = ADDR_WIDTH'((16'(r_row) + 16'(w_tap_r)) * 16'(IMG_W)
                              + 16'(r_col) + 16'(w_tap_c));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and decoded status/read outputs.
  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    pix_rd_en = 1'b0;
    pix_addr  = '0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH: begin
        pix_rd_en = 1'b1;
        pix_addr  = w_addr;
        if (w_last_tap) w_next = S_CAPTURE;
      end
      S_CAPTURE: w_next = S_COMPUTE;
      S_COMPUTE: w_next = S_OUT;
      S_OUT: begin
        if (w_hs) w_next = (w_last_row && w_last_col) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Window position and tap counters; advance in raster order on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
          end
        end
        S_FETCH: if (!w_last_tap) r_k <= r_k + 4'd1;
        S_OUT: begin
          if (w_hs && !(w_last_row && w_last_col)) begin
            r_k <= '0;
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tap registers: RAM data lags the address by one cycle, so it lands in tap k-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_px[i] <= '0;
    end else if (r_state == S_FETCH && r_k != 4'd0) begin
      r_px[r_k - 4'd1] <= pix_rd_data;
    end else if (r_state == S_CAPTURE) begin
      r_px[8] <= pix_rd_data;
    end
  end

  // Result register: capture mac_out once all taps are stable, hold until transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_out_valid <= 1'b1;
      r_out_data  <= mac_out;
      r_out_row   <= r_row;
      r_out_col   <= r_col;
    end else if (r_state == S_OUT && w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  assign px0       = r_px[0];
  assign px1       = r_px[1];
  assign px2       = r_px[2];
  assign px3       = r_px[3];
  assign px4       = r_px[4];
  assign px5       = r_px[5];
  assign px6       = r_px[6];
  assign px7       = r_px[7];
  assign px8       = r_px[8];
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// Bench for conv3x3_window_ctrl on a 4x4 map: behavioural pixel RAM and
// mac_3x3 model, expected results queued at start and popped on transfers.
module tb_conv3x3_window_ctrl;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pix_rd_en;
  logic [AW-1:0] pix_addr;
  logic [DW-1:0] pix_rd_data;
  logic [DW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [DW-1:0] mac_out;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_row, out_col;
  logic [2:0]    dbg_state;

  logic signed [DW-1:0] mem [0:W*H-1];
  logic signed [DW-1:0] w   [0:8];
  logic signed [31:0]   acc;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int e0 = 0;
  int hs_count = 0;
  int done_count = 0;
  int done_cyc = 0;

  conv3x3_window_ctrl #(
    .DATA_WIDTH(DW), .FRAC_BITS(8), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_rd_data(pix_rd_data),
    .px0(p0), .px1(p1), .px2(p2), .px3(p3), .px4(p4),
    .px5(p5), .px6(p6), .px7(p7), .px8(p8),
    .mac_out(mac_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .dbg_state(dbg_state)
  );

  // clock / RAM / mac model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pix_rd_en) pix_rd_data <= mem[pix_addr];
  end

  always_comb begin
    acc = $signed(p0) * w[0] + $signed(p1) * w[1] + $signed(p2) * w[2]
        + $signed(p3) * w[3] + $signed(p4) * w[4] + $signed(p5) * w[5]
        + $signed(p6) * w[6] + $signed(p7) * w[7] + $signed(p8) * w[8];
    mac_out = 16'(acc >>> 8);
  end

  // driver tasks
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      hs_count++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_extra got row=%0d col=%0d data=%0d, no result expected",
                 out_row, out_col, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_row, out_col, out_data} !== e) begin
          n_err++;
          $display("FAIL scoreboard got row=%0d col=%0d data=%0d expected row=%0d col=%0d data=%0d",
                   out_row, out_col, out_data, e[31:24], e[23:16], e[15:0]);
        end
      end
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic run_to_done(input int budget);
    int d0 = done_count;
    int n = 0;
    while (done_count == d0 && n < budget) begin
      tick();
      n++;
    end
    n_vec++;
    if (done_count == d0) begin
      n_err++;
      $display("FAIL done_timeout no done within %0d cycles", budget);
    end
  endtask

  task automatic push_expected();
    for (int r = 0; r <= H - 3; r++) begin
      for (int c = 0; c <= W - 3; c++) begin
        int s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(mem[(r + i) * W + c + j]) * int'(w[3 * i + j]);
        exp_q.push_back({8'(r), 8'(c), 16'(s >>> 8)});
      end
    end
  endtask

  task automatic load_ones();
    for (int a = 0; a < W * H; a++) mem[a] = 16'sd256;
    for (int k = 0; k < 9; k++) w[k] = 16'sd256;
  endtask

  task automatic load_ramp();
    for (int a = 0; a < W * H; a++) mem[a] = 16'(a * 256);
    for (int k = 0; k < 9; k++) w[k] = 16'sd0;
    w[4] = 16'sd256;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    load_ones();
    #2;
    n_vec++;
    if ({busy, done, pix_rd_en, out_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags got %b expected 0000", {busy, done, pix_rd_en, out_valid});
    end
    n_vec++;
    if (pix_addr !== '0) begin
      n_err++;
      $display("FAIL reset_addr got %0d expected 0", pix_addr);
    end
    n_vec++;
    if ((p0 | p1 | p2 | p3 | p4 | p5 | p6 | p7 | p8) !== '0) begin
      n_err++;
      $display("FAIL reset_taps got nonzero tap expected all 0");
    end
    n_vec++;
    if ({out_data, out_row, out_col} !== 32'd0) begin
      n_err++;
      $display("FAIL reset_out got data=%0d row=%0d col=%0d expected 0", out_data, out_row, out_col);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state got %0d expected %0d", dbg_state, ST_IDLE);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_all_ones_addr();
    int a1[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int a2[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int d0;
    load_ones();
    hs_count = 0;
    push_expected();
    d0 = done_count;
    pulse_start();
    for (int j = 0; j < 9; j++) begin
      n_vec++;
      if (pix_rd_en !== 1'b1 || pix_addr !== AW'(a1[j])) begin
        n_err++;
        $display("FAIL addr_win1 step %0d got en=%b addr=%0d expected en=1 addr=%0d",
                 j, pix_rd_en, pix_addr, a1[j]);
      end
      tick();
    end
    n_vec++;
    if (pix_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL capture_rd_en got %b expected 0", pix_rd_en);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_early got %b at E10 expected 0", out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL valid_e11 got %b at E11 expected 1", out_valid);
    end
    tick();
    for (int j = 0; j < 9; j++) begin
      n_vec++;
      if (pix_rd_en !== 1'b1 || pix_addr !== AW'(a2[j])) begin
        n_err++;
        $display("FAIL addr_win2 step %0d got en=%b addr=%0d expected en=1 addr=%0d",
                 j, pix_rd_en, pix_addr, a2[j]);
      end
      tick();
    end
    run_to_done(200);
    n_vec++;
    if (done_cyc - e0 != 48) begin
      n_err++;
      $display("FAIL done_latency got %0d expected 48", done_cyc - e0);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_after_done got %b expected 0", busy);
    end
    repeat (4) tick();
    n_vec++;
    if (hs_count != 4 || exp_q.size() != 0 || done_count != d0 + 1) begin
      n_err++;
      $display("FAIL ones_counts got results=%0d pending=%0d dones=%0d expected 4 0 1",
               hs_count, exp_q.size(), done_count - d0);
    end
  endtask

  task automatic test_ramp();
    load_ramp();
    hs_count = 0;
    exp_q.push_back({8'd0, 8'd0, 16'd1280});
    exp_q.push_back({8'd0, 8'd1, 16'd1536});
    exp_q.push_back({8'd1, 8'd0, 16'd2304});
    exp_q.push_back({8'd1, 8'd1, 16'd2560});
    pulse_start();
    run_to_done(200);
    n_vec++;
    if (hs_count != 4 || exp_q.size() != 0 || done_cyc - e0 != 48) begin
      n_err++;
      $display("FAIL ramp_counts got results=%0d pending=%0d done_at=%0d expected 4 0 48",
               hs_count, exp_q.size(), done_cyc - e0);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    load_ramp();
    hs_count = 0;
    push_expected();
    pulse_start();
    while (!(hs_count == 1 && out_valid === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    n_vec++;
    if (!(hs_count == 1 && out_valid === 1'b1)) begin
      n_err++;
      $display("FAIL second_valid_timeout got results=%0d valid=%b expected 1 1", hs_count, out_valid);
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      n_vec++;
      if ({out_valid, out_row, out_col, out_data} !== {1'b1, 8'd0, 8'd1, 16'd1536}
          || pix_rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d got v=%b row=%0d col=%0d data=%0d rd=%b expected 1 0 1 1536 0",
                 s, out_valid, out_row, out_col, out_data, pix_rd_en);
      end
      tick();
    end
    out_ready = 1'b1;
    run_to_done(200);
    n_vec++;
    if (done_cyc - e0 != 53 || hs_count != 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_done got done_at=%0d results=%0d pending=%0d expected 53 4 0",
               done_cyc - e0, hs_count, exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int n = 0;
    int d0;
    load_ramp();
    hs_count = 0;
    push_expected();
    d0 = done_count;
    pulse_start();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(200);
    n_vec++;
    if (done_cyc - e0 != 48) begin
      n_err++;
      $display("FAIL busy_start_latency got %0d expected 48", done_cyc - e0);
    end
    repeat (15) tick();
    n_vec++;
    if (hs_count != 4 || exp_q.size() != 0 || done_count != d0 + 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_counts got results=%0d pending=%0d dones=%0d busy=%b expected 4 0 1 0",
               hs_count, exp_q.size(), done_count - d0, busy);
    end
  endtask

  task automatic test_reset_mid_pass();
    int d0;
    load_ramp();
    hs_count = 0;
    push_expected();
    d0 = done_count;
    pulse_start();
    repeat (21) tick();
    n_vec++;
    if (dbg_state !== ST_CAPTURE) begin
      n_err++;
      $display("FAIL mid_state got %0d expected %0d", dbg_state, ST_CAPTURE);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, pix_rd_en, out_valid} !== 4'b0000 || pix_addr !== '0
        || (p0 | p1 | p2 | p3 | p4 | p5 | p6 | p7 | p8) !== '0
        || {out_data, out_row, out_col} !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs got flags=%b addr=%0d data=%0d row=%0d col=%0d expected all 0",
               {busy, done, pix_rd_en, out_valid}, pix_addr, out_data, out_row, out_col);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL mid_reset_state got %0d expected %0d", dbg_state, ST_IDLE);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (done_count != d0 || hs_count != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_abort got dones=%0d results=%0d busy=%b expected 0 1 0",
               done_count - d0, hs_count, busy);
    end
    exp_q.delete();
    hs_count = 0;
    push_expected();
    pulse_start();
    run_to_done(200);
    n_vec++;
    if (hs_count != 4 || exp_q.size() != 0 || done_cyc - e0 != 48 || done_count != d0 + 1) begin
      n_err++;
      $display("FAIL rerun_after_reset got results=%0d pending=%0d done_at=%0d dones=%0d expected 4 0 48 1",
               hs_count, exp_q.size(), done_cyc - e0, done_count - d0);
    end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_all_ones_addr();
    test_ramp();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_pass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
